// File: rtl/urv_fetch_buffer_pkg.sv
// Shared types and constants for the uRV instruction-fetch front end.
// No logic; holds the fetch entry layout, depth and reset address default.
// Imported by the fetch buffer top and its prefetch FIFO.
package urv_fetch_buffer_pkg;

    localparam logic [31:0] URV_RESET_VECTOR = 32'h0000_0000;
    localparam int          URV_FETCH_DEPTH  = 2;

    typedef logic [1:0] fcnt_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ir;
    } fetch_entry_t;

    // Force an address onto a word boundary.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/urv_fetch_buffer_if.sv
// Bus bundle between fetch front end, instruction memory, decode and execute.
// Pure wiring, no latency.
// master = fetch buffer side, slave = environment (memory/decode/execute).
interface urv_fetch_buffer_if;

    logic        f_stall_i;
    logic        x_bra_i;
    logic [31:0] x_bra_target_i;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic [31:0] im_data_i;
    logic        im_valid_i;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;
    logic        f_valid_o;

    modport master (
        input  f_stall_i, x_bra_i, x_bra_target_i, im_data_i, im_valid_i,
        output im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
    );

    modport slave (
        output f_stall_i, x_bra_i, x_bra_target_i, im_data_i, im_valid_i,
        input  im_addr_o, im_rd_o, f_ir_o, f_pc_o, f_valid_o
    );

endinterface

// File: rtl/urv_fetch_buffer_fifo.sv
// Two-entry {pc, ir} prefetch FIFO with synchronous flush.
// Head is visible combinationally; push lands one cycle later.
// Push on full is ignored unless popping the same cycle; pop on empty is ignored.
module urv_fetch_fifo
    import urv_fetch_buffer_pkg::*;
(
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t wdata,
    output fetch_entry_t rdata,
    output logic         full,
    output logic         empty,
    output fcnt_t        count
);

    fetch_entry_t mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_push;
    logic         do_pop;

    assign empty   = (count == 2'd0);
    assign full    = (count == 2'(URV_FETCH_DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    // Pointer and occupancy tracking; flush wins over everything else.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) wr_ptr <= ~wr_ptr;
            if (do_pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // Storage write; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk_i) begin
        if (do_push && !flush) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/urv_fetch_buffer.sv
// Fetch front end: sequential word reads, 2-deep prefetch, PC-tagged output register.
// Latency: request at N, 1-cycle memory returns at N+1, f_valid_o at N+2 (bypass path).
// Backpressure: f_stall_i holds outputs; credits (outst + cnt < 2) throttle im_rd_o.
module urv_fetch_buffer
    import urv_fetch_buffer_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = URV_RESET_VECTOR
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    urv_fetch_buffer_if.master    bus
);

    logic [31:0]  fpc;
    logic [31:0]  rpc;
    fcnt_t        outst;
    fcnt_t        drop;
    fcnt_t        cnt;
    fcnt_t        inflight;

    logic         issue;
    logic         accept;
    logic         load_head;
    logic         bypass;
    logic         fifo_push;
    logic         fifo_pop;
    logic         fifo_full;
    logic         fifo_empty;
    fetch_entry_t fifo_head;
    fetch_entry_t resp;

    logic [31:0]  out_pc;
    logic [31:0]  out_ir;
    logic         out_valid;

    // Each outstanding request owns a FIFO slot, so responses never overflow.
    assign inflight  = outst + cnt;
    assign issue     = !rst_i && !bus.x_bra_i && (inflight < 2'(URV_FETCH_DEPTH));
    // A response arriving with a redirect, or while stale returns remain, is discarded.
    assign accept    = bus.im_valid_i && (drop == 2'd0) && !bus.x_bra_i;
    assign load_head = !bus.f_stall_i && !fifo_empty && !bus.x_bra_i;
    assign bypass    = !bus.f_stall_i && fifo_empty && accept;
    assign fifo_push = accept && !bypass;
    assign fifo_pop  = load_head;
    assign resp      = '{pc: rpc, ir: bus.im_data_i};

    assign bus.im_rd_o   = issue;
    assign bus.im_addr_o = fpc;
    assign bus.f_pc_o    = out_pc;
    assign bus.f_ir_o    = out_ir;
    assign bus.f_valid_o = out_valid;

    urv_fetch_fifo u_fifo (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (bus.x_bra_i),
        .wdata (resp),
        .rdata (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (cnt)
    );

    // Request/response address tracking, credit count and stale-return bookkeeping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fpc   <= RESET_VECTOR;
            rpc   <= RESET_VECTOR;
            outst <= 2'd0;
            drop  <= 2'd0;
        end else begin
            outst <= outst + 2'(issue) - 2'(bus.im_valid_i);
            if (bus.x_bra_i) begin
                fpc  <= word_align(bus.x_bra_target_i);
                rpc  <= word_align(bus.x_bra_target_i);
                drop <= outst - 2'(bus.im_valid_i);
            end else begin
                if (issue)  fpc <= fpc + 32'd4;
                if (accept) rpc <= rpc + 32'd4;
                if (bus.im_valid_i && (drop != 2'd0)) drop <= drop - 2'd1;
            end
        end
    end

    // Decode-facing register: FIFO head first, else bypass, held under stall.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_pc    <= 32'd0;
            out_ir    <= 32'd0;
            out_valid <= 1'b0;
        end else if (bus.x_bra_i) begin
            out_valid <= 1'b0;
        end else if (!bus.f_stall_i) begin
            if (!fifo_empty) begin
                out_pc    <= fifo_head.pc;
                out_ir    <= fifo_head.ir;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_pc    <= rpc;
                out_ir    <= bus.im_data_i;
                out_valid <= 1'b1;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_urv_fetch_buffer.sv
// Directed bench for urv_fetch_buffer with a variable-latency in-order memory model.
module tb_urv_fetch_buffer;

    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   lat;
    int   cyc;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } req_t;

    req_t q[$];

    urv_fetch_buffer_if bus();

    urv_fetch_buffer #(.RESET_VECTOR(32'h0000_0100)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // In-order memory: each request returns lat cycles later, data = addr ^ MASK.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            cyc = 0;
            bus.im_valid_i <= 1'b0;
            bus.im_data_i  <= 32'd0;
        end else begin
            if (bus.im_valid_i) void'(q.pop_front());
            if (bus.im_rd_o) q.push_back('{bus.im_addr_o, cyc + lat});
            cyc = cyc + 1;
            if (q.size() > 0 && q[0].due <= cyc) begin
                bus.im_valid_i <= 1'b1;
                bus.im_data_i  <= q[0].addr ^ MASK;
            end else begin
                bus.im_valid_i <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Walk forward until n valid outputs are seen; each must continue the stream from start.
    task automatic expect_stream(input string tag, input logic [31:0] start, input int n,
                                 input int budget);
        logic [31:0] exp_pc;
        int          got;
        exp_pc = start;
        got    = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            if (bus.f_valid_o) begin
                chk({tag, "_pc"}, bus.f_pc_o, exp_pc);
                chk({tag, "_ir"}, bus.f_ir_o, exp_pc ^ MASK);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            @(negedge clk);
        end
        chk({tag, "_count"}, got, n);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0;
        bad   = 0;
        lat   = 1;
        rst   = 1'b1;
        bus.f_stall_i      = 1'b0;
        bus.x_bra_i        = 1'b0;
        bus.x_bra_target_i = 32'd0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", bus.f_valid_o, 0);
        chk("rst_ir",    bus.f_ir_o,    0);
        chk("rst_pc",    bus.f_pc_o,    0);
        chk("rst_rd",    bus.im_rd_o,   0);
        chk("rst_addr",  bus.im_addr_o, 32'h100);

        // Sequential fetch, 1-cycle memory
        rst = 1'b0;
        #1;
        chk("first_rd",   bus.im_rd_o,   1);
        chk("first_addr", bus.im_addr_o, 32'h100);
        @(negedge clk);
        chk("c1_addr",  bus.im_addr_o, 32'h104);
        chk("c1_valid", bus.f_valid_o, 0);
        @(negedge clk);
        chk("c2_valid", bus.f_valid_o, 1);
        chk("c2_pc",    bus.f_pc_o,    32'h100);
        chk("c2_ir",    bus.f_ir_o,    32'hA5A5_0100);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            chk("seq_valid", bus.f_valid_o, 1);
            chk("seq_pc",    bus.f_pc_o,    32'h100 + 32'(4 * k));
        end

        // Stall for 5 cycles
        bus.f_stall_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.f_valid_o, 1);
            chk("stall_pc",    bus.f_pc_o,    32'h10C);
            chk("stall_ir",    bus.f_ir_o,    32'hA5A5_010C);
            if (i >= 1) chk("stall_rd", bus.im_rd_o, 0);
        end
        bus.f_stall_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("drain_valid", bus.f_valid_o, 1);
            chk("drain_pc",    bus.f_pc_o,    32'h110 + 32'(4 * k));
        end

        // Quiesce, switch to 3-cycle memory, set up two outstanding requests
        bus.f_stall_i = 1'b1;
        repeat (4) @(negedge clk);
        lat = 3;
        chk("quiesce_rd", bus.im_rd_o, 0);
        bus.x_bra_i        = 1'b1;
        bus.x_bra_target_i = 32'h0000_1803;
        #1;
        chk("bra1_rd", bus.im_rd_o, 0);
        @(negedge clk);
        bus.x_bra_i = 1'b0;
        #1;
        chk("bra1_valid", bus.f_valid_o, 0);
        chk("bra1_rd1",   bus.im_rd_o,   1);
        chk("bra1_addr",  bus.im_addr_o, 32'h1800);
        @(negedge clk);
        chk("bra1_rd2",   bus.im_rd_o,   1);
        chk("bra1_addr2", bus.im_addr_o, 32'h1804);
        @(negedge clk);
        chk("bra1_credit", bus.im_rd_o, 0);

        // Redirect to 0x2000 with both requests outstanding
        bus.x_bra_i        = 1'b1;
        bus.x_bra_target_i = 32'h0000_2000;
        bus.f_stall_i      = 1'b0;
        #1;
        chk("bra2_rd", bus.im_rd_o, 0);
        @(negedge clk);
        bus.x_bra_i = 1'b0;
        expect_stream("bra2", 32'h2000, 3, 20);

        // Redirect coinciding with a response and a stall, then a second redirect
        for (int c = 0; c < 10 && !bus.im_valid_i; c++) @(negedge clk);
        chk("resp_seen", bus.im_valid_i, 1);
        bus.f_stall_i      = 1'b1;
        bus.x_bra_i        = 1'b1;
        bus.x_bra_target_i = 32'h0000_0300;
        #1;
        chk("bra3_rd", bus.im_rd_o, 0);
        @(negedge clk);
        chk("bra3_valid", bus.f_valid_o, 0);
        bus.f_stall_i      = 1'b0;
        bus.x_bra_target_i = 32'h0000_0400;
        #1;
        chk("bra4_rd", bus.im_rd_o, 0);
        @(negedge clk);
        bus.x_bra_i = 1'b0;
        chk("bra4_valid", bus.f_valid_o, 0);
        expect_stream("b2b", 32'h400, 4, 30);

        // Address wrap with 1-cycle memory
        bus.f_stall_i = 1'b1;
        repeat (8) @(negedge clk);
        lat = 1;
        bus.f_stall_i      = 1'b0;
        bus.x_bra_i        = 1'b1;
        bus.x_bra_target_i = 32'hFFFF_FFF8;
        @(negedge clk);
        bus.x_bra_i = 1'b0;
        #1;
        chk("wrap_rd",   bus.im_rd_o,   1);
        chk("wrap_addr", bus.im_addr_o, 32'hFFFF_FFF8);
        @(negedge clk);
        chk("wrap_v0",    bus.f_valid_o, 0);
        chk("wrap_addr2", bus.im_addr_o, 32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_v1",  bus.f_valid_o, 1);
        chk("wrap_pc1", bus.f_pc_o,    32'hFFFF_FFF8);
        @(negedge clk);
        chk("wrap_pc2", bus.f_pc_o,    32'hFFFF_FFFC);
        @(negedge clk);
        chk("wrap_v3",  bus.f_valid_o, 1);
        chk("wrap_pc3", bus.f_pc_o,    32'h0000_0000);
        chk("wrap_ir3", bus.f_ir_o,    32'hA5A5_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
